uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart.sv | 216 +++++++++++++++++++++
 tb/tb_uart.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// uart -- 8N1 serial transceiver with a shared 16x oversample baud tick.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   uart_rxd   serial receive line (asynchronous, idle high)
//   uart_txd   serial transmit line (registered, idle high)
//   rx_data    last byte received with a good stop bit
//   rx_avail   a received byte is pending
//   rx_error   the last frame had a framing error (stop bit low)
//   rx_ack     consumer acknowledge, clears rx_avail and rx_error
//   tx_data    byte to transmit, captured when tx_wr is accepted
//   tx_wr      one-cycle transmit request, ignored while tx_busy
//   tx_busy    transmitter occupied
//
// RX and TX FSM states (both use the same encoding)
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a start bit (RX) or a request (TX)
//   ST_START | start bit: RX re-checks it at tick 8, TX drives it low
//   ST_DATA  | eight data bits, LSB first, 16 ticks each
//   ST_STOP  | stop bit: RX samples it mid-bit, TX drives it high
module uart #(
    parameter int freq_hz = 100000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy
);

    localparam int DIV   = freq_hz / (baud * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // Free-running baud divider: tick on terminal count, then reload.
    logic [DIV_W-1:0] div_cnt;
    logic             baud_tick;

    always_ff @(posedge clk) begin
        if (!reset_n)
            div_cnt <= '0;
        else if (div_cnt == '0)
            div_cnt <= DIV_LOAD;
        else
            div_cnt <= div_cnt - 1'b1;
    end

    assign baud_tick = (div_cnt == '0);

    // Two-flop synchronizer, cleared to the idle level.
    logic rxd_meta, rxd_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // ---------------------------------------------------------------- RX
    state_t     rx_state, rx_state_next;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bcnt;
    logic [7:0] rx_shreg;
    logic       rx_sample, rx_shift, rx_frame_ok, rx_frame_err;

    always_ff @(posedge clk) begin
        if (!reset_n)
            rx_state <= ST_IDLE;
        else
            rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            ST_IDLE:  if (!rxd_sync) rx_state_next = ST_START;
            ST_START: if (rx_sample) rx_state_next = rxd_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_sample && rx_bcnt == 3'd0) rx_state_next = ST_STOP;
            ST_STOP:  if (rx_sample) rx_state_next = ST_IDLE;
            default:  rx_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_sample    = baud_tick && (rx_tcnt == 4'd0) && (rx_state != ST_IDLE);
        rx_shift     = rx_sample && (rx_state == ST_DATA);
        rx_frame_ok  = rx_sample && (rx_state == ST_STOP) && rxd_sync;
        rx_frame_err = rx_sample && (rx_state == ST_STOP) && !rxd_sync;
    end

    // The tick timer is preloaded to 7 while idle so the start bit is
    // re-checked 8 ticks in (mid-bit); every later sample is 16 ticks on.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_tcnt  <= 4'd7;
            rx_bcnt  <= 3'd7;
            rx_shreg <= 8'h00;
            rx_data  <= 8'h00;
            rx_avail <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            if (rx_state == ST_IDLE) begin
                rx_tcnt <= 4'd7;
                rx_bcnt <= 3'd7;
            end else if (baud_tick) begin
                rx_tcnt <= (rx_tcnt == 4'd0) ? 4'd15 : rx_tcnt - 4'd1;
            end
            if (rx_shift) begin
                rx_shreg <= {rxd_sync, rx_shreg[7:1]};
                rx_bcnt  <= rx_bcnt - 3'd1;
            end
            // Later assignments win: a frame completing in the ack cycle
            // leaves its flag set.
            if (rx_ack) begin
                rx_avail <= 1'b0;
                rx_error <= 1'b0;
            end
            if (rx_frame_ok) begin
                rx_data  <= rx_shreg;
                rx_avail <= 1'b1;
                rx_error <= 1'b0;
            end
            if (rx_frame_err)
                rx_error <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- TX
    state_t     tx_state, tx_state_next;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bcnt;
    logic [7:0] tx_shreg;
    logic       tx_pend, tx_accept, tx_bit_end;

    always_ff @(posedge clk) begin
        if (!reset_n)
            tx_state <= ST_IDLE;
        else
            tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            ST_IDLE:  if (tx_pend && baud_tick) tx_state_next = ST_START;
            ST_START: if (tx_bit_end) tx_state_next = ST_DATA;
            ST_DATA:  if (tx_bit_end && tx_bcnt == 3'd0) tx_state_next = ST_STOP;
            ST_STOP:  if (tx_bit_end) tx_state_next = ST_IDLE;
            default:  tx_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_busy    = tx_pend || (tx_state != ST_IDLE);
        tx_accept  = tx_wr && !tx_busy;
        tx_bit_end = baud_tick && (tx_tcnt == 4'd0) && (tx_state != ST_IDLE);
    end

    // tx_pend holds an accepted byte until the next baud tick so that the
    // start bit begins on the tick grid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_pend  <= 1'b0;
            tx_tcnt  <= 4'd15;
            tx_bcnt  <= 3'd7;
            tx_shreg <= 8'h00;
            uart_txd <= 1'b1;
        end else begin
            if (tx_accept) begin
                tx_shreg <= tx_data;
                tx_pend  <= 1'b1;
            end
            if (tx_state == ST_IDLE) begin
                tx_tcnt <= 4'd15;
                tx_bcnt <= 3'd7;
                if (tx_pend && baud_tick) begin
                    tx_pend  <= 1'b0;
                    uart_txd <= 1'b0;
                end
            end else if (baud_tick) begin
                tx_tcnt <= (tx_tcnt == 4'd0) ? 4'd15 : tx_tcnt - 4'd1;
            end
            if (tx_bit_end) begin
                case (tx_state)
                    ST_START: uart_txd <= tx_shreg[0];
                    ST_DATA: begin
                        if (tx_bcnt == 3'd0) begin
                            uart_txd <= 1'b1;
                        end else begin
                            uart_txd <= tx_shreg[1];
                            tx_shreg <= {1'b0, tx_shreg[7:1]};
                            tx_bcnt  <= tx_bcnt - 3'd1;
                        end
                    end
                    ST_STOP: uart_txd <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart.sv
module tb_uart;

    localparam int BIT = 864;

    logic       clk;
    logic       reset_n;
    logic       uart_txd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic       rxd_drv;
    logic       loop_en;
    logic       rxd;

    int checks = 0;
    int errors = 0;
    int rst_cnt = 0;
    logic [7:0] tx_q[$];

    assign rxd = loop_en ? uart_txd : rxd_drv;

    uart dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .uart_rxd (rxd),
        .uart_txd (uart_txd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge reset_n) rst_cnt++;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       ack_in_stop;
        logic       ack_after;
        logic [7:0] exp_data;
        logic       exp_avail;
        logic       exp_err;
    } rx_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Waits up to n cycles, returning early if a reset arrives.
    task automatic mon_wait(input int n, input int tag);
        for (int c = 0; c < n; c++) begin
            if (rst_cnt != tag) break;
            @(negedge clk);
        end
    endtask

    // Line monitor: decodes every TX frame mid-bit and pops the scoreboard.
    initial begin : tx_monitor
        int         tag;
        logic       s0, sp;
        logic [7:0] bits;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && uart_txd === 1'b0) begin
                tag = rst_cnt;
                mon_wait(BIT / 2 - 1, tag);
                s0 = uart_txd;
                for (int b = 0; b < 8; b++) begin
                    mon_wait(BIT, tag);
                    bits[b] = uart_txd;
                end
                mon_wait(BIT, tag);
                sp = uart_txd;
                if (rst_cnt == tag) begin
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected_frame: actual %0h required none", bits);
                    end else begin
                        exp = tx_q.pop_front();
                        check("tx_start_bit", s0, 1'b0);
                        check("tx_byte", bits, exp);
                        check("tx_stop_bit", sp, 1'b1);
                    end
                end
            end
        end
    end

    task automatic tx_pulse(input logic [7:0] d, input bit push);
        @(negedge clk);
        tx_data = d;
        tx_wr   = 1'b1;
        if (push) tx_q.push_back(d);
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    // Counts cycles with tx_busy high (bounded); optionally fires a 0x55
    // write while busy at cycle inject_at.
    task automatic wait_busy_low(input int inject_at, output int n);
        n = 0;
        while (tx_busy && n < 20000) begin
            n++;
            if (n == inject_at) begin
                tx_data = 8'h55;
                tx_wr   = 1'b1;
            end else begin
                tx_wr = 1'b0;
            end
            @(negedge clk);
        end
        tx_wr = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_ok, input logic ack_in_stop);
        logic saw_low;
        logic got;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rxd_drv = d[b];
            repeat (BIT) @(negedge clk);
        end
        saw_low = 1'b0;
        got     = 1'b0;
        rxd_drv = stop_ok;
        if (ack_in_stop) rx_ack = 1'b1;
        for (int c = 0; c < BIT; c++) begin
            if (!stop_ok && c == 600) rxd_drv = 1'b1;
            @(negedge clk);
            if (rx_ack) begin
                if (!rx_avail) saw_low = 1'b1;
                else if (saw_low) begin
                    rx_ack = 1'b0;
                    got    = 1'b1;
                end
            end
        end
        rx_ack  = 1'b0;
        rxd_drv = 1'b1;
        if (ack_in_stop) check("rx_ack_collision_frame_wins", got, 1'b1);
        repeat (300) @(negedge clk);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        rx_vec_t vecs[4];
        int      n;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};

        reset_n = 1'b0;
        rx_ack  = 1'b0;
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_avail", rx_avail, 1'b0);
        check("rst_error", rx_error, 1'b0);
        check("rst_data", rx_data, 8'h00);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Loopback 0x67 with an ignored write while busy, then 0x00 written
        // in the cycle right after busy drops.
        loop_en = 1'b1;
        tx_pulse(8'h67, 1'b1);
        check("tx_busy_after_wr", tx_busy, 1'b1);
        wait_busy_low(2000, n);
        check_range("tx_busy_len_67", n, 10 * BIT, 10 * BIT + 60);
        check("lb_data_67", rx_data, 8'h67);
        check("lb_avail_67", rx_avail, 1'b1);
        check("lb_error_67", rx_error, 1'b0);
        tx_data = 8'h00;
        tx_wr   = 1'b1;
        rx_ack  = 1'b1;
        tx_q.push_back(8'h00);
        @(negedge clk);
        tx_wr  = 1'b0;
        rx_ack = 1'b0;
        check("tx_wr_after_busy_accepted", tx_busy, 1'b1);
        check("ack_clears_avail", rx_avail, 1'b0);
        wait_busy_low(0, n);
        check_range("tx_busy_len_00", n, 10 * BIT, 10 * BIT + 60);
        check("lb_data_00", rx_data, 8'h00);
        check("lb_avail_00", rx_avail, 1'b1);
        check("lb_error_00", rx_error, 1'b0);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        check("ack_clears_avail_00", rx_avail, 1'b0);

        // Glitch on the receive line.
        loop_en = 1'b0;
        repeat (20) @(negedge clk);
        rxd_drv = 1'b0;
        repeat (200) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (700) @(negedge clk);
        check("glitch_avail", rx_avail, 1'b0);
        check("glitch_error", rx_error, 1'b0);
        check("glitch_data", rx_data, 8'h00);

        // Table-driven received frames.
        for (int i = 0; i < 4; i++) begin
            drive_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].ack_in_stop);
            check($sformatf("rx_vec%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("rx_vec%0d_avail", i), rx_avail, vecs[i].exp_avail);
            check($sformatf("rx_vec%0d_error", i), rx_error, vecs[i].exp_err);
            if (vecs[i].ack_after) begin
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                check($sformatf("rx_vec%0d_ack_avail", i), rx_avail, 1'b0);
                check($sformatf("rx_vec%0d_ack_error", i), rx_error, 1'b0);
            end
        end

        // Reset in the middle of data bit 3, then a full frame.
        loop_en = 1'b1;
        tx_pulse(8'hB4, 1'b0);
        n = 0;
        while (uart_txd && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("txd_start_seen", (n < 200), 1'b1);
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midtx_rst_txd", uart_txd, 1'b1);
        check("midtx_rst_busy", tx_busy, 1'b0);
        check("midtx_rst_avail", rx_avail, 1'b0);
        check("midtx_rst_data", rx_data, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        tx_pulse(8'h9E, 1'b1);
        wait_busy_low(0, n);
        check_range("tx_busy_len_9e", n, 10 * BIT, 10 * BIT + 60);
        check("post_rst_data", rx_data, 8'h9E);
        check("post_rst_avail", rx_avail, 1'b1);
        check("post_rst_error", rx_error, 1'b0);
        repeat (10) @(negedge clk);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
